// File: rtl/trigger_sequencer_pkg.sv
`default_nettype none
// trig_seq_pkg: FSM state encoding and default parameters shared by trigger_sequencer and trig_fifo.
// Rev 1.0
package trig_seq_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_e;

  localparam int unsigned DEFAULT_DEPTH       = 4;
  localparam int unsigned DEFAULT_ACK_TIMEOUT = 8;

endpackage
`default_nettype wire

// File: rtl/trigger_sequencer_fifo.sv
`default_nettype none
// trig_fifo: DEPTH x 1 synchronous FIFO with full/empty/level and asynchronous reset.
// Rev 1.0
module trig_fifo
  import trig_seq_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     din,
  input  logic                     pop,
  output logic                     dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign level = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // Ready is a function of occupancy only, so a full FIFO refuses a push even when popping.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + (AW+1)'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/trigger_sequencer.sv
`default_nettype none
// trigger_sequencer: queues mode-tagged trigger requests and issues them to the delay counter one at a time.
// Optional TRIG_SEQ_STATS_EN adds done_cnt/drop_cnt outputs. Rev 1.0
module trigger_sequencer
  import trig_seq_pkg::*;
#(
  parameter int unsigned DEPTH       = DEFAULT_DEPTH,
  parameter int unsigned ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  input  logic                    req_mode,
  output logic                    req_ready,
  input  logic                    cf,
  output logic                    tr,
  output logic                    mode,
  output logic                    done,
  output logic                    err,
  input  logic                    err_clr,
  output logic [$clog2(DEPTH):0]  level
`ifdef TRIG_SEQ_STATS_EN
  ,
  output logic [15:0]             done_cnt,
  output logic [7:0]              drop_cnt
`endif
);

  localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic       tr_q, tr_d;
  logic       mode_q, mode_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic [7:0] to_cnt_q, to_cnt_d;
  logic       pop;
  logic       timeout;
  logic       fifo_dout, fifo_full, fifo_empty;

  trig_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (req_valid),
    .din   (req_mode),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  assign req_ready = ~fifo_full;
  assign tr        = tr_q;
  assign mode      = mode_q;
  assign done      = done_q;
  assign err       = err_q;

  always_comb begin
    state_d  = state_q;
    tr_d     = 1'b0;
    mode_d   = mode_q;
    done_d   = 1'b0;
    to_cnt_d = to_cnt_q;
    pop      = 1'b0;
    timeout  = 1'b0;
    case (state_q)
      IDLE: begin
        // Emptiness comes from registered occupancy, so a fresh push is never bypassed.
        if (!fifo_empty && cf) begin
          pop     = 1'b1;
          mode_d  = fifo_dout;
          tr_d    = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        to_cnt_d = '0;
        state_d  = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!cf) begin
          state_d = WAIT_DONE;
        end else if (to_cnt_q == TO_LAST) begin
          timeout = 1'b1;
          state_d = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 8'd1;
        end
      end
      WAIT_DONE: begin
        if (cf) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    err_d = timeout ? 1'b1 : (err_clr ? 1'b0 : err_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      tr_q     <= 1'b0;
      mode_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      to_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      tr_q     <= tr_d;
      mode_q   <= mode_d;
      done_q   <= done_d;
      err_q    <= err_d;
      to_cnt_q <= to_cnt_d;
    end
  end

`ifdef TRIG_SEQ_STATS_EN
  logic [15:0] done_cnt_q, done_cnt_d;
  logic [7:0]  drop_cnt_q, drop_cnt_d;

  always_comb begin
    done_cnt_d = done_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (done_d && done_cnt_q != 16'hFFFF) begin
      done_cnt_d = done_cnt_q + 16'd1;
    end
    if (timeout && drop_cnt_q != 8'hFF) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      done_cnt_q <= done_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign done_cnt = done_cnt_q;
  assign drop_cnt = drop_cnt_q;
`endif

endmodule
`default_nettype wire
